// File: rtl/raccoon_pkg.sv
// Shared constants and types for the Raccoon polynomial add/sub path.
// Coefficients are 25 bits, packed two per 50-bit RAM word.
package raccoon_pkg;

    localparam int WORD_W     = 50;
    localparam int COEF_W     = 25;
    localparam int POLY_WORDS = 256;

    localparam logic [COEF_W-1:0] Q_25 = 25'd33292289;
    localparam logic [COEF_W-1:0] Q_24 = 25'd16515073;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/flag_delay.sv
// N-stage registered 1-bit delay line with synchronous reset (N >= 1).
// Latency N cycles; no backpressure.
module flag_delay #(
    parameter int N = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [N-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= din;
            for (int i = 1; i < N; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign dout = sr_q[N-1];

endmodule

// File: rtl/poly_addsub_ctrl.sv
// Sequencer streaming len packed words from two source banks through the add/sub datapath to a destination bank.
// done arrives len+RD_LAT+DP_LAT+1 cycles after start; no backpressure, the datapath is assumed always ready.
module poly_addsub_ctrl #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 50,
    parameter int RD_LAT = 1,
    parameter int DP_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_sub,
    input  logic              q_mod,
    input  logic [ADDR_W-1:0] src1_base,
    input  logic [ADDR_W-1:0] src2_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd1_addr,
    output logic [ADDR_W-1:0] rd2_addr,
    input  logic [WORD_W-1:0] rd1_data,
    input  logic [WORD_W-1:0] rd2_data,
    output logic              dp_in_flag,
    output logic              dp_sub,
    output logic              dp_q_mod,
    output logic [WORD_W-1:0] dp_din1,
    output logic [WORD_W-1:0] dp_din2,
    input  logic [WORD_W-1:0] dp_dout,
    input  logic              dp_out_flag,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data
);

    import raccoon_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   rcnt_q, rcnt_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] src1_q, src2_q, dst_q;
    logic              sub_q, qmod_q;
    logic              cfg_ld;
    logic              res_due;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        wcnt_d  = wcnt_q;
        cfg_ld  = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        done    = 1'b0;
        busy    = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_ld  = 1'b1;
                    rcnt_d  = '0;
                    wcnt_d  = '0;
                    state_d = (len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rd_en  = 1'b1;
                rcnt_d = rcnt_q + 1'b1;
                if (rcnt_q == len_q - 1'b1) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Results landing in IDLE/DONE belong to an aborted operation and are dropped.
        if ((state_q == ST_ISSUE || state_q == ST_DRAIN) && dp_out_flag) begin
            wr_en  = 1'b1;
            wcnt_d = wcnt_q + 1'b1;
        end

        // Looking at the next write count lets DONE follow the last write directly.
        if (state_q == ST_DRAIN && wcnt_d == len_q) begin
            state_d = ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
            wcnt_q  <= '0;
            len_q   <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            dst_q   <= '0;
            sub_q   <= 1'b0;
            qmod_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            wcnt_q  <= wcnt_d;
            if (cfg_ld) begin
                len_q  <= len;
                src1_q <= src1_base;
                src2_q <= src2_base;
                dst_q  <= dst_base;
                sub_q  <= op_sub;
                qmod_q <= q_mod;
            end
            // The datapath must return one result exactly DP_LAT cycles after each operand pair.
            if (res_due) begin
                assert (dp_out_flag);
            end
        end
    end

    flag_delay #(.N(RD_LAT)) u_in_flag (
        .clk  (clk),
        .rst  (rst),
        .din  (rd_en),
        .dout (dp_in_flag)
    );

    flag_delay #(.N(DP_LAT)) u_res_due (
        .clk  (clk),
        .rst  (rst),
        .din  (dp_in_flag),
        .dout (res_due)
    );

    assign rd1_addr = src1_q + rcnt_q[ADDR_W-1:0];
    assign rd2_addr = src2_q + rcnt_q[ADDR_W-1:0];
    assign wr_addr  = dst_q + wcnt_q[ADDR_W-1:0];

    // Held from the start latch until the next start so late datapath stages see stable controls.
    assign dp_sub   = sub_q;
    assign dp_q_mod = qmod_q;
    assign dp_din1  = rd1_data;
    assign dp_din2  = rd2_data;
    assign wr_data  = dp_dout;

endmodule

// File: tb/tb_poly_addsub_ctrl.sv
// Directed bench for poly_addsub_ctrl with registered-read RAM and two-stage modular add/sub models.
module tb_poly_addsub_ctrl;

    localparam logic [25:0] QA = 26'd33292289;
    localparam logic [25:0] QB = 26'd16515073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op_sub = 1'b0;
    logic        q_mod = 1'b0;
    logic [7:0]  src1_base = '0, src2_base = '0, dst_base = '0;
    logic [8:0]  len = '0;
    logic        busy, done, rd_en, dp_in_flag, dp_sub, dp_q_mod, wr_en;
    logic [7:0]  rd1_addr, rd2_addr, wr_addr;
    logic [49:0] rd1_data = '0, rd2_data = '0;
    logic [49:0] dp_din1, dp_din2, dp_dout, wr_data;
    logic        dp_out_flag;

    always #5 clk = ~clk;

    poly_addsub_ctrl #(.ADDR_W(8), .WORD_W(50), .RD_LAT(1), .DP_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .q_mod(q_mod),
        .src1_base(src1_base), .src2_base(src2_base), .dst_base(dst_base), .len(len),
        .busy(busy), .done(done), .rd_en(rd_en), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .rd1_data(rd1_data), .rd2_data(rd2_data), .dp_in_flag(dp_in_flag), .dp_sub(dp_sub),
        .dp_q_mod(dp_q_mod), .dp_din1(dp_din1), .dp_din2(dp_din2), .dp_dout(dp_dout),
        .dp_out_flag(dp_out_flag), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    // ---------------- environment models ----------------
    logic [49:0] src1_mem [256];
    logic [49:0] src2_mem [256];
    logic [49:0] dst_mem  [256];

    always @(posedge clk) begin
        if (rd_en) begin
            rd1_data <= src1_mem[rd1_addr];
            rd2_data <= src2_mem[rd2_addr];
        end
        if (wr_en) dst_mem[wr_addr] <= wr_data;
    end

    function automatic logic [24:0] mod_op(input logic [24:0] a, input logic [24:0] b,
                                           input logic sub, input logic qm);
        logic [25:0] q, s;
        q = qm ? QB : QA;
        if (sub) begin
            s = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + q - {1'b0, b});
        end else begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= q) s = s - q;
        end
        return s[24:0];
    endfunction

    logic        s1_vld = 1'b0, s2_vld = 1'b0;
    logic [49:0] s1_dat = '0, s2_dat = '0;
    always @(posedge clk) begin
        s1_vld <= dp_in_flag;
        s1_dat <= {mod_op(dp_din1[49:25], dp_din2[49:25], dp_sub, dp_q_mod),
                   mod_op(dp_din1[24:0],  dp_din2[24:0],  dp_sub, dp_q_mod)};
        s2_vld <= s1_vld;
        s2_dat <= s1_dat;
    end
    assign dp_out_flag = s2_vld;
    assign dp_dout     = s2_dat;

    // ---------------- monitor ----------------
    int ec = 0;
    always @(posedge clk) ec <= ec + 1;

    int rd_tot = 0, wr_tot = 0, done_tot = 0, wrap_tot = 0, oidle_tot = 0;
    int rd_rise_ec = 0, rd_last_ec = 0, wr_rise_ec = 0, wr_last_ec = 0, pin_rise_ec = 0, done_ec = 0;
    logic       rd_prev = 1'b0, wr_prev = 1'b0, pin_prev = 1'b0;
    logic [7:0] prev_a = '0, wr_last_addr = '0;
    logic [1:0] wr_cfg = '0;

    always @(negedge clk) begin
        if (rd_en) begin
            rd_tot <= rd_tot + 1;
            if (!rd_prev) rd_rise_ec <= ec;
            rd_last_ec <= ec;
            if (prev_a == 8'd255 && rd1_addr == 8'd0) wrap_tot <= wrap_tot + 1;
            prev_a <= rd1_addr;
        end
        rd_prev <= rd_en;
        if (dp_in_flag && !pin_prev) pin_rise_ec <= ec;
        pin_prev <= dp_in_flag;
        if (wr_en) begin
            wr_tot <= wr_tot + 1;
            if (!wr_prev) wr_rise_ec <= ec;
            wr_last_ec   <= ec;
            wr_last_addr <= wr_addr;
            wr_cfg       <= {dp_sub, dp_q_mod};
        end
        wr_prev <= wr_en;
        if (done) begin
            done_tot <= done_tot + 1;
            done_ec  <= ec;
        end
        if (dp_out_flag && !busy) oidle_tot <= oidle_tot + 1;
    end

    // ---------------- checking helpers ----------------
    int total = 0, bad = 0;
    int t0 = 0, rd0 = 0, wr0 = 0, dn0 = 0, wp0 = 0, oi0 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_op(input logic [8:0] l, input logic [7:0] a1, input logic [7:0] a2,
                            input logic [7:0] d, input logic sb, input logic qm);
        len = l; src1_base = a1; src2_base = a2; dst_base = d; op_sub = sb; q_mod = qm;
        start = 1'b1;
        t0 = ec; rd0 = rd_tot; wr0 = wr_tot; dn0 = done_tot; wp0 = wrap_tot;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int n;
        n = 0;
        while (done_tot == dn0 && n < 600) begin
            step();
            n++;
        end
        chk({tag, "_done_cyc"}, 64'(done_ec - t0), 64'(exp_cyc));
        step();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int a = 0; a < 256; a++) begin
            src1_mem[a] = '0;
            src2_mem[a] = '0;
        end
        repeat (3) step();
        chk("reset_ctl", {busy, done, rd_en, wr_en, dp_in_flag, dp_sub, dp_q_mod}, 0);
        chk("reset_addr", {rd1_addr, rd2_addr, wr_addr}, 0);
        rst = 1'b0;
        step();

        // add, len 4: (5,7) + (3,2) = (8,9)
        for (int a = 0; a < 4; a++) begin
            src1_mem[10 + a] = {25'd5, 25'd7};
            src2_mem[20 + a] = {25'd3, 25'd2};
        end
        start_op(9'd4, 8'd10, 8'd20, 8'd40, 1'b0, 1'b0);
        chk("add_busy", busy, 1);
        wait_done("add", 8);
        chk("add_rd_n", 64'(rd_tot - rd0), 4);
        chk("add_wr_n", 64'(wr_tot - wr0), 4);
        chk("add_rd_first", 64'(rd_rise_ec - t0), 1);
        chk("add_rd_last", 64'(rd_last_ec - t0), 4);
        chk("add_pin_first", 64'(pin_rise_ec - t0), 2);
        chk("add_wr_first", 64'(wr_rise_ec - t0), 4);
        chk("add_wr_last", 64'(wr_last_ec - t0), 7);
        chk("add_dst40", dst_mem[40], {25'd8, 25'd9});
        chk("add_dst43", dst_mem[43], {25'd8, 25'd9});
        chk("add_last_addr", wr_last_addr, 43);
        chk("add_idle", {busy, done}, 0);

        // sub with negative wrap, both moduli
        src1_mem[50] = {25'd3, 25'd10};
        src2_mem[60] = {25'd5, 25'd4};
        start_op(9'd1, 8'd50, 8'd60, 8'd70, 1'b1, 1'b1);
        wait_done("sub_q24", 5);
        chk("sub_q24_dat", dst_mem[70], {25'd16515071, 25'd6});
        chk("sub_q24_cfg", wr_cfg, 2'b11);
        start_op(9'd1, 8'd50, 8'd60, 8'd71, 1'b1, 1'b0);
        wait_done("sub_q25", 5);
        chk("sub_q25_dat", dst_mem[71], {25'd33292287, 25'd6});
        chk("sub_q25_cfg", wr_cfg, 2'b10);

        // add reduction past q
        src1_mem[51] = {25'd33292288, 25'd0};
        src2_mem[61] = {25'd5, 25'd0};
        start_op(9'd1, 8'd51, 8'd61, 8'd72, 1'b0, 1'b0);
        wait_done("add_red", 5);
        chk("add_red_dat", dst_mem[72], {25'd4, 25'd0});

        // zero length
        start_op(9'd0, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0);
        wait_done("zero", 1);
        chk("zero_rd_n", 64'(rd_tot - rd0), 0);
        chk("zero_wr_n", 64'(wr_tot - wr0), 0);

        // full bank with source address wrap
        for (int a = 0; a < 256; a++) begin
            src1_mem[a] = {25'(a), 25'd1};
            src2_mem[a] = {25'd1000, 25'(a)};
        end
        start_op(9'd256, 8'd200, 8'd0, 8'd100, 1'b0, 1'b0);
        wait_done("full", 260);
        chk("full_rd_n", 64'(rd_tot - rd0), 256);
        chk("full_wr_n", 64'(wr_tot - wr0), 256);
        chk("full_wrap", 64'(wrap_tot - wp0), 1);
        chk("full_k0", dst_mem[100], {25'd1200, 25'd1});
        chk("full_k55", dst_mem[155], {25'd1255, 25'd56});
        chk("full_k56", dst_mem[156], {25'd1000, 25'd57});
        chk("full_k255", dst_mem[99], {25'd1199, 25'd256});

        // start while busy is ignored
        start_op(9'd8, 8'h30, 8'h40, 8'h60, 1'b0, 1'b0);
        step();
        step();
        start = 1'b1; len = 9'd2; src1_base = 8'h90; dst_base = 8'h80;
        step();
        start = 1'b0;
        wait_done("busy_start", 12);
        chk("busy_wr_n", 64'(wr_tot - wr0), 8);
        chk("busy_done_n", 64'(done_tot - dn0), 1);
        chk("busy_last_addr", wr_last_addr, 8'h67);
        chk("busy_dst60", dst_mem[8'h60], {25'd1048, 25'd65});
        chk("busy_dst67", dst_mem[8'h67], {25'd1055, 25'd72});

        // reset in the middle of a len 16 operation
        start_op(9'd16, 8'd0, 8'd0, 8'hA0, 1'b1, 1'b1);
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("rst_ctl", {busy, done, rd_en, wr_en, dp_in_flag, dp_sub, dp_q_mod}, 0);
        chk("rst_addr", {rd1_addr, rd2_addr, wr_addr}, 0);
        rst = 1'b0;
        wr0 = wr_tot;
        oi0 = oidle_tot;
        repeat (4) step();
        chk("rst_no_wr", 64'(wr_tot - wr0), 0);
        chk("rst_pending_seen", 64'(oidle_tot - oi0 > 0), 1);
        start_op(9'd2, 8'd5, 8'd6, 8'hB0, 1'b0, 1'b0);
        wait_done("post_rst", 6);
        chk("post_rst_wr_n", 64'(wr_tot - wr0), 2);
        chk("post_rst_dst0", dst_mem[8'hB0], {25'd1005, 25'd7});
        chk("post_rst_dst1", dst_mem[8'hB1], {25'd1006, 25'd8});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
